// File: rtl/v68k_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : v68k_bus_pkg                                                  |
// | Description : Bus strobe polarities shared with the CPU core, plus the      |
// |               responder state encoding used by bus_responder_ram.           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package v68k_bus_pkg;

  // Strobes on the 68000 bus are active-low.
  localparam logic DS_ON        = 1'b0;
  localparam logic DS_OFF       = 1'b1;
  localparam logic AS_STROBE    = 1'b0;
  localparam logic AS_OFF       = 1'b1;
  localparam logic RW_READ      = 1'b1;
  localparam logic RW_WRITE     = 1'b0;
  localparam logic DTACK_ASSERT = 1'b1;

  typedef enum logic [2:0] {
    RS_IDLE   = 3'd0,
    RS_WAIT   = 3'd1,
    RS_ACK    = 3'd2,
    RS_IGNORE = 3'd3,
    RS_ERR    = 3'd4
  } resp_state_e;

endpackage
`default_nettype wire

// File: rtl/bus_responder_ram_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : bus_responder_ram_if                                          |
// | Description : 68000-style control/address bus between the CPU core and     |
// |               its bus slaves.                                               |
// |   A[23:1]  word address          AS   address strobe (0 = valid)          |
// |   UDS/LDS  byte-lane strobes      RW   1 = read, 0 = write                 |
// |   DTACK    data acknowledge       BERR bus error                           |
// |   The 16-bit data bus is a plain inout on each endpoint so the tristate    |
// |   resolves at board level.                                                 |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface bus_responder_ram_if;

  logic [23:1] A;
  logic        AS;
  logic        UDS;
  logic        LDS;
  logic        RW;
  logic        DTACK;
  logic        BERR;

  modport master (
    output A, AS, UDS, LDS, RW,
    input  DTACK, BERR
  );

  modport slave (
    input  A, AS, UDS, LDS, RW,
    output DTACK, BERR
  );

endinterface
`default_nettype wire

// File: rtl/bus_word_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bus_word_ram                                                  |
// | Description : Synchronous 16-bit word RAM, 2^ADDR_BITS words, with a 2-bit  |
// |               byte-write enable. One write port and one read port, both    |
// |               on CLK. Read data is registered and holds while i_re is low. |
// |   CLK      clock                 i_we/i_be/i_waddr/i_wdata  write port    |
// |   i_re/i_raddr/o_rdata  read port                                          |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module bus_word_ram #(
  parameter int ADDR_BITS = 10
) (
  input  wire logic                 CLK,
  input  wire logic                 i_we,
  input  wire logic [1:0]           i_be,
  input  wire logic [ADDR_BITS-1:0] i_waddr,
  input  wire logic [15:0]          i_wdata,
  input  wire logic                 i_re,
  input  wire logic [ADDR_BITS-1:0] i_raddr,
  output wire logic [15:0]          o_rdata
);

  localparam int c_DEPTH = 1 << ADDR_BITS;

  // Each byte lane is its own array so a lane write never touches the other.
  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [7:0] r_mem [c_DEPTH];
    logic [7:0] r_q;

    always_ff @(posedge CLK) begin
      if (i_we && i_be[g]) begin
        r_mem[i_waddr] <= i_wdata[g*8 +: 8];
      end
      if (i_re) begin
        r_q <= r_mem[i_raddr];
      end
    end

    assign o_rdata[g*8 +: 8] = r_q;
  end

endmodule
`default_nettype wire

// File: rtl/bus_responder_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bus_responder_ram                                             |
// | Description : 68000 bus slave backed by a local word RAM. Accepts a cycle  |
// |               on AS low with a data strobe, waits WAIT_STATES clocks, then |
// |               acknowledges with DTACK (driving D on reads, writing the     |
// |               selected byte lanes on writes) until AS is released.         |
// |   CLK    clock                 RESET  synchronous reset, active-high      |
// |   bus    slave modport (A, AS, UDS, LDS, RW, DTACK, BERR)                  |
// |   D      16-bit data bus, driven only during the read data phase          |
// | Option      : `define BUS_RESPONDER_BERR_EN to answer out-of-window cycles |
// |               with BERR; otherwise they are ignored and BERR is tied 0.    |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module bus_responder_ram
  import v68k_bus_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_STATES = 2
) (
  input  wire logic          CLK,
  input  wire logic          RESET,
  bus_responder_ram_if.slave bus,
  inout  wire        [15:0]  D
);

  localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_STATES);

  resp_state_e            r_state;
  resp_state_e            w_nxt_state;
  logic [3:0]             r_cnt;
  logic [3:0]             w_nxt_cnt;
  logic                   r_dtack;
  logic                   w_nxt_dtack;
  logic                   r_d_oe;
  logic                   w_nxt_d_oe;

  // Cycle attributes captured at acceptance; later bus changes are ignored.
  logic [ADDR_BITS-1:0]   r_word;
  logic                   r_rw;
  logic                   r_uds;
  logic                   r_lds;

  logic                   w_latch;
  logic                   w_ram_we;
  logic                   w_ram_re;
  logic [15:0]            w_rdata;

  logic                   w_start;
  logic                   w_as_off;
  logic                   w_in_window;

  assign w_start     = (bus.AS == AS_STROBE) && ((bus.UDS == DS_ON) || (bus.LDS == DS_ON));
  assign w_as_off    = (bus.AS == AS_OFF);
  assign w_in_window = (bus.A[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]);

`ifdef BUS_RESPONDER_BERR_EN
  logic r_berr;
  logic w_nxt_berr;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_dtack = r_dtack;
    w_nxt_d_oe  = r_d_oe;
    w_latch     = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
`ifdef BUS_RESPONDER_BERR_EN
    w_nxt_berr  = r_berr;
`endif

    case (r_state)
      RS_IDLE: begin
        // AS low with no data strobe yet is the start of a write; keep waiting.
        if (w_start) begin
          w_latch = 1'b1;
          if (w_in_window) begin
            w_nxt_state = RS_WAIT;
            w_nxt_cnt   = c_WAIT_LOAD;
          end else begin
`ifdef BUS_RESPONDER_BERR_EN
            w_nxt_state = RS_ERR;
            w_nxt_cnt   = c_WAIT_LOAD;
`else
            w_nxt_state = RS_IGNORE;
`endif
          end
        end
      end

      RS_WAIT: begin
        if (w_as_off) begin
          w_nxt_state = RS_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_nxt_state = RS_ACK;
          w_nxt_dtack = DTACK_ASSERT;
          if (r_rw == RW_READ) begin
            w_ram_re   = 1'b1;
            w_nxt_d_oe = 1'b1;
          end else begin
            w_ram_we   = 1'b1;
          end
        end else begin
          w_nxt_cnt = r_cnt - 4'd1;
        end
      end

      RS_ACK: begin
        if (w_as_off) begin
          w_nxt_state = RS_IDLE;
          w_nxt_dtack = ~DTACK_ASSERT;
          w_nxt_d_oe  = 1'b0;
        end
      end

      RS_IGNORE: begin
        if (w_as_off) begin
          w_nxt_state = RS_IDLE;
        end
      end

`ifdef BUS_RESPONDER_BERR_EN
      RS_ERR: begin
        // Counts like RS_WAIT, then holds BERR until the master lets go.
        if (w_as_off) begin
          w_nxt_state = RS_IDLE;
          w_nxt_berr  = 1'b0;
        end else if (!r_berr) begin
          if (r_cnt == 4'd0) begin
            w_nxt_berr = 1'b1;
          end else begin
            w_nxt_cnt = r_cnt - 4'd1;
          end
        end
      end
`endif

      default: begin
        w_nxt_state = RS_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= RS_IDLE;
      r_cnt   <= 4'd0;
      r_dtack <= ~DTACK_ASSERT;
      r_d_oe  <= 1'b0;
`ifdef BUS_RESPONDER_BERR_EN
      r_berr  <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_dtack <= w_nxt_dtack;
      r_d_oe  <= w_nxt_d_oe;
`ifdef BUS_RESPONDER_BERR_EN
      r_berr  <= w_nxt_berr;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (w_latch) begin
      r_word <= bus.A[ADDR_BITS:1];
      r_rw   <= bus.RW;
      r_uds  <= bus.UDS;
      r_lds  <= bus.LDS;
    end
  end

  // Write data is taken from D on the acknowledging edge; a reset on that
  // same edge suppresses the commit.
  bus_word_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .CLK     (CLK),
    .i_we    (w_ram_we && !RESET),
    .i_be    ({r_uds == DS_ON, r_lds == DS_ON}),
    .i_waddr (r_word),
    .i_wdata (D),
    .i_re    (w_ram_re),
    .i_raddr (r_word),
    .o_rdata (w_rdata)
  );

  // The RAM read register only loads on entry to RS_ACK, so D is stable for
  // the whole data phase.
  assign D         = r_d_oe ? w_rdata : 16'hzzzz;
  assign bus.DTACK = r_dtack;
`ifdef BUS_RESPONDER_BERR_EN
  assign bus.BERR  = r_berr;
`else
  assign bus.BERR  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_responder_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bus_responder_ram                                          |
// | Description : Directed self-checking bench for bus_responder_ram with a    |
// |               shadow memory and a queue of expected read data.             |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_bus_responder_ram;
  import v68k_bus_pkg::*;

  localparam int          WS   = 2;
  localparam int          AB   = 10;
  localparam logic [23:0] BASE = 24'h000000;

  logic        CLK     = 1'b0;
  logic        RESET   = 1'b1;
  wire  [15:0] D;
  logic [15:0] tb_d    = 16'h0000;
  logic        tb_d_oe = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [15:0] model [int];
  logic [15:0] exp_q [$];

  assign D = tb_d_oe ? tb_d : 16'hzzzz;

  bus_responder_ram_if bus ();

  bus_responder_ram #(
    .BASE_ADDR   (BASE),
    .ADDR_BITS   (AB),
    .WAIT_STATES (WS)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus),
    .D     (D)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; the next posedge samples the cycle.
  task automatic start_cycle(input logic [23:1] addr, input logic rw,
                             input logic uds, input logic lds, input logic [15:0] wd);
    bus.A   = addr;
    bus.RW  = rw;
    bus.UDS = uds;
    bus.LDS = lds;
    bus.AS  = AS_STROBE;
    tb_d    = wd;
    tb_d_oe = (rw == RW_WRITE);
  endtask

  // Returns the number of posedges, counting the sampling edge, until DTACK.
  task automatic wait_ack(output int lat);
    lat = 0;
    while (bus.DTACK !== DTACK_ASSERT && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic release_bus(input string tag);
    bus.AS  = AS_OFF;
    bus.UDS = DS_OFF;
    bus.LDS = DS_OFF;
    tb_d_oe = 1'b0;
    @(negedge CLK);
    chk({tag, "_dtack_drop"}, bus.DTACK, 1'b0);
    chk({tag, "_d_release"}, dut.r_d_oe, 1'b0);
  endtask

  task automatic full_cycle(input string tag, input logic [23:1] addr, input logic rw,
                            input logic uds, input logic lds, input logic [15:0] wd,
                            input int hold);
    int          lat;
    int          key;
    logic [15:0] cur;
    logic [15:0] exp;
    key = int'(addr[AB:1]);
    exp = 16'h0000;
    if (rw == RW_READ) exp_q.push_back(model[key]);
    start_cycle(addr, rw, uds, lds, wd);
    wait_ack(lat);
    chk({tag, "_latency"}, lat - 1, WS + 1);
    if (rw == RW_READ) begin
      exp = exp_q.pop_front();
      chk({tag, "_rdata"}, D, exp);
    end else begin
      cur = model.exists(key) ? model[key] : 16'h0000;
      if (uds == DS_ON) cur[15:8] = wd[15:8];
      if (lds == DS_ON) cur[7:0]  = wd[7:0];
      model[key] = cur;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      bus.A  = ~bus.A;   // address/RW wiggle during the data phase is ignored
      bus.RW = ~bus.RW;
      chk({tag, "_hold_dtack"}, bus.DTACK, 1'b1);
      if (rw == RW_READ) chk({tag, "_hold_d"}, D, exp);
    end
    release_bus(tag);
  endtask

  initial begin
    int lat;
    bus.A   = '0;
    bus.AS  = AS_OFF;
    bus.UDS = DS_OFF;
    bus.LDS = DS_OFF;
    bus.RW  = RW_READ;

    repeat (3) @(negedge CLK);
    chk("reset_dtack", bus.DTACK, 1'b0);
    chk("reset_berr", bus.BERR, 1'b0);
    chk("reset_d_release", dut.r_d_oe, 1'b0);
    RESET = 1'b0;
    @(negedge CLK);

    // Word write / read
    full_cycle("wr_beef", 23'h000004, RW_WRITE, DS_ON, DS_ON, 16'hBEEF, 0);
    full_cycle("rd_beef", 23'h000004, RW_READ,  DS_ON, DS_ON, 16'h0000, 0);

    // Byte lanes
    full_cycle("wr_1234", 23'h000010, RW_WRITE, DS_ON,  DS_ON,  16'h1234, 0);
    full_cycle("wr_upper", 23'h000010, RW_WRITE, DS_ON,  DS_OFF, 16'hAA00, 0);
    full_cycle("rd_aa34", 23'h000010, RW_READ,  DS_ON,  DS_ON,  16'h0000, 0);
    full_cycle("wr_lower", 23'h000010, RW_WRITE, DS_OFF, DS_ON,  16'h0055, 0);
    full_cycle("rd_aa55", 23'h000010, RW_READ,  DS_OFF, DS_ON,  16'h0000, 0);

    // Early abort: AS released at t0+1 during WAIT
    full_cycle("wr_zero", 23'h000020, RW_WRITE, DS_ON, DS_ON, 16'h0000, 0);
    start_cycle(23'h000020, RW_WRITE, DS_ON, DS_ON, 16'hFFFF);
    @(negedge CLK);
    bus.AS  = AS_OFF;
    bus.UDS = DS_OFF;
    bus.LDS = DS_OFF;
    tb_d_oe = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("abort_no_dtack", bus.DTACK, 1'b0);
    end
    full_cycle("rd_after_abort", 23'h000020, RW_READ, DS_ON, DS_ON, 16'h0000, 0);

    // Handshake hold, then a new cycle right after the idle edge
    full_cycle("hold_rd", 23'h000010, RW_READ, DS_ON, DS_ON, 16'h0000, 5);
    full_cycle("b2b_rd", 23'h000004, RW_READ, DS_ON, DS_ON, 16'h0000, 0);

    // Out-of-window access
    start_cycle(23'h400000, RW_READ, DS_ON, DS_ON, 16'h0000);
`ifdef BUS_RESPONDER_BERR_EN
    lat = 0;
    while (bus.BERR !== 1'b1 && lat < 40) begin
      @(negedge CLK);
      lat++;
      chk("oow_no_dtack", bus.DTACK, 1'b0);
    end
    chk("oow_berr_latency", lat - 1, WS + 1);
    chk("oow_d_release", dut.r_d_oe, 1'b0);
    bus.AS  = AS_OFF;
    bus.UDS = DS_OFF;
    bus.LDS = DS_OFF;
    @(negedge CLK);
    chk("oow_berr_clear", bus.BERR, 1'b0);
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("oow_no_dtack", bus.DTACK, 1'b0);
      chk("oow_no_berr", bus.BERR, 1'b0);
    end
    bus.AS  = AS_OFF;
    bus.UDS = DS_OFF;
    bus.LDS = DS_OFF;
    @(negedge CLK);
`endif
    @(negedge CLK);
    full_cycle("rd_after_oow", 23'h000010, RW_READ, DS_ON, DS_ON, 16'h0000, 0);

    // Reset during the ACK phase of a read
    start_cycle(23'h000004, RW_READ, DS_ON, DS_ON, 16'h0000);
    wait_ack(lat);
    chk("rst_pre_dtack", bus.DTACK, 1'b1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst_dtack", bus.DTACK, 1'b0);
    chk("rst_d_release", dut.r_d_oe, 1'b0);
    RESET   = 1'b0;
    bus.AS  = AS_OFF;
    bus.UDS = DS_OFF;
    bus.LDS = DS_OFF;
    @(negedge CLK);
    full_cycle("rd_after_rst", 23'h000004, RW_READ, DS_ON, DS_ON, 16'h0000, 0);
    full_cycle("rd_after_rst2", 23'h000020, RW_READ, DS_ON, DS_ON, 16'h0000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_responder_ram.md
Name: bus_responder_ram

Overview:
- Asynchronous-style 68000 bus slave: local word RAM that answers the CPU core's bus cycles.
- Decodes A/AS/UDS/LDS/RW, inserts programmable wait states, then asserts DTACK.
- Drives D on reads and writes the selected byte lanes on writes.
- First memory/peripheral endpoint hung off the CPU bus for fetch and data bring-up.

Parameters:
- BASE_ADDR, 24'h000000: byte base address of the window; must be aligned to 2^(ADDR_BITS+1).
- ADDR_BITS, 10: word-address bits, giving 2^ADDR_BITS 16-bit words (2 KiB at default).
- WAIT_STATES, 2: CLK cycles inserted between cycle acceptance and DTACK; range 0-15.

Ports:
- CLK  input  1  clock
- RESET  input  1  synchronous reset, active-high
- A  input  23  word address A[23:1]
- AS  input  1  address strobe, 0 = valid
- UDS  input  1  upper data strobe (D[15:8]), 0 = selected
- LDS  input  1  lower data strobe (D[7:0]), 0 = selected
- RW  input  1  1 = read, 0 = write
- D  inout  16  data bus; driven only during the read data phase, else high-Z
- DTACK  output  1  1 = data valid / write accepted
- BERR  output  1  1 = bus error (out-of-window access); only active with BERR_EN

Behaviour:
- Reset (sync, active-high): state=IDLE, DTACK=0, BERR=0, D released (Z), wait counter=0. RAM contents are not cleared. Reset mid-cycle aborts the cycle; no write is committed.
- All bus inputs are sampled on posedge CLK. Outputs are registered.
- IDLE:
  - Accept a cycle when AS=0 and (UDS=0 or LDS=0). Latch A, RW, UDS, LDS.
  - If AS=0 with both strobes off, stay in IDLE (write DS lags AS).
  - In-window iff A[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]; go to WAIT with cnt=WAIT_STATES.
  - Out-of-window: go to ERR if BERR_EN, else IGNORE.
- WAIT:
  - Each edge: if AS=1, the cycle is aborted; go to IDLE with no write, no DTACK.
  - Else if cnt=0, go to ACK. Read: D <= mem[A[ADDR_BITS:1]], drive enabled. Write: mem bytes written from D sampled this edge, D[15:8] if UDS=0, D[7:0] if LDS=0. DTACK <= 1.
  - Else cnt <= cnt-1.
- Latency: AS/DS sampled low at edge t0 gives DTACK=1 visible after edge t0+WAIT_STATES+1. WAIT_STATES=0 gives 1 cycle.
- ACK: hold DTACK=1 and D driven (read) until AS sampled 1. Then DTACK<=0, D<=Z, go to IDLE. Minimum one idle edge between cycles. Changes to A/RW during ACK are ignored (latched values used).
- IGNORE: no response; wait for AS=1, then go to IDLE. The master hangs; this is deliberate without BERR_EN.
- Read of a single lane drives the full word; the master selects the byte.
- Back-to-back cycles: a new AS falling edge is only accepted from IDLE.

Optional Feature:
- Macro: BUS_RESPONDER_BERR_EN.
- Defined: out-of-window cycles enter ERR. BERR<=1 after WAIT_STATES+1 edges (same timing as DTACK), DTACK stays 0, D stays Z. BERR holds until AS=1, then drops and the block returns to IDLE. Abort by AS=1 during the wait gives no BERR.
- Undefined: ERR state is not compiled and BERR is tied 0. Out-of-window cycles go to IGNORE.

Decomposition:
- Shared package v68k_bus_pkg holds:
  - DS_ON/DS_OFF, AS_STROBE/AS_OFF, RW_READ/RW_WRITE constants (shared with the CPU core);
  - responder state encoding IDLE/WAIT/ACK/IGNORE/ERR (3 bits);
  - DTACK_ASSERT=1.
- One sub-module, bus_word_ram: synchronous word RAM with 2-bit byte-write enable. One read port and one write port, both on CLK.

Test Plan:
- Word write/read: WAIT_STATES=2, write D=16'hBEEF to word addr 0x004 with UDS=LDS=0 → DTACK=1 three edges after AS sampled low. Read back the same address → D=16'hBEEF with DTACK.
- Byte lanes: word 0x010 holds 16'h1234; write 16'hAAxx with UDS=0 only → reads 16'hAA34. Write 16'hxx55 with LDS=0 only → reads 16'hAA55.
- Early abort: AS raised at edge t0+1 during WAIT on a write of 16'hFFFF to 0x020 (prior 16'h0000) → DTACK never asserts and a read returns 16'h0000.
- Handshake hold: AS kept low 5 extra cycles after DTACK → DTACK and D stay stable. After AS=1, DTACK=0 and D=Z on the next edge. A new cycle is accepted the following edge.
- Out-of-window: BASE_ADDR=0, access A=23'h400000:
  - with BERR_EN: BERR=1 after WAIT_STATES+1 edges, DTACK=0, BERR cleared after AS=1;
  - without BERR_EN: no DTACK or BERR for 20 cycles.
- Reset during ACK of a read: DTACK=0 and D=Z after the reset edge. Previously written data is still readable.
